// File: rtl/tm1638_bus_scheduler_pkg.sv
// Shared types and default constants for the TM1638 command-port scheduler.
package tm1638_sched_types;

  localparam int unsigned WORD_WIDTH = 18;

  typedef enum logic [0:0] {
    SCHED_IDLE  = 1'b0,
    SCHED_BURST = 1'b1
  } sched_state_t;

endpackage

// File: rtl/tm1638_bus_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from ptr_i with wrap.
module rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  int unsigned cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = (32'(ptr_i) + i) % NUM_REQ;
      if (!any_o && req_i[cand[IDX_W-1:0]]) begin
        any_o                     = 1'b1;
        idx_o                     = cand[IDX_W-1:0];
        grant_o[cand[IDX_W-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tm1638_bus_scheduler.sv
// Round-robin, transaction-atomic arbiter sharing the spi_fifo write port between
// TM1638 command producers, with a stall watchdog that reclaims a hung grant.
module tm1638_bus_scheduler
  import tm1638_sched_types::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned WORD_WIDTH     = tm1638_sched_types::WORD_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned IDX_W = $clog2(NUM_REQ)
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst,
  input  logic [NUM_REQ-1:0]            i_Req,
  input  logic [NUM_REQ-1:0]            i_Valid,
  input  logic [NUM_REQ-1:0]            i_Last,
  input  logic [NUM_REQ*WORD_WIDTH-1:0] i_Data,
  output logic [NUM_REQ-1:0]            o_Grant,
  output logic [NUM_REQ-1:0]            o_Ready,
  input  logic                          i_SPI_FIFO_Full,
  output logic [WORD_WIDTH-1:0]         o_Data,
  output logic                          o_Write,
  output logic [IDX_W-1:0]              o_Active_Src,
  output logic                          o_Timeout
);

  localparam int unsigned    CNT_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  sched_state_t         state_q, state_d;
  logic [IDX_W-1:0]     next_q, next_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 timeout_q, timeout_d;

  logic [NUM_REQ-1:0]   pick_grant;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;
  logic                 xfer_c;
  logic [IDX_W-1:0]     next_after_c;
  logic [WORD_WIDTH-1:0] word_c;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i   (i_Req),
    .ptr_i   (next_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // Zero-latency forwarding path; grant_q is already one-hot of idx_q.
  assign o_Ready      = (state_q == SCHED_BURST && !i_SPI_FIFO_Full) ? grant_q : '0;
  assign xfer_c       = |(o_Ready & i_Valid);
  assign word_c       = i_Data[32'(idx_q)*WORD_WIDTH +: WORD_WIDTH];
  assign o_Write      = xfer_c;
  assign o_Data       = xfer_c ? word_c : '0;
  assign next_after_c = (32'(idx_q) == NUM_REQ - 1) ? '0 : idx_q + IDX_W'(1);

  assign o_Grant      = grant_q;
  assign o_Active_Src = idx_q;
  assign o_Timeout    = timeout_q;

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q   <= SCHED_IDLE;
      next_q    <= '0;
      idx_q     <= '0;
      grant_q   <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      next_q    <= next_d;
      idx_q     <= idx_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    next_d    = next_q;
    idx_d     = idx_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    unique case (state_q)
      SCHED_IDLE: begin
        if (pick_any) begin
          grant_d = pick_grant;
          idx_d   = pick_idx;
          cnt_d   = '0;
          state_d = SCHED_BURST;
        end
      end
      SCHED_BURST: begin
        if (xfer_c) begin
          cnt_d = '0;
          if (i_Last[idx_q]) begin
            grant_d = '0;
            next_d  = next_after_c;
            state_d = SCHED_IDLE;
          end
        end else if (!i_SPI_FIFO_Full) begin
          // Only genuine stalls count; a full FIFO holds the counter.
          if (cnt_q == CNT_MAX) begin
            timeout_d = 1'b1;
            grant_d   = '0;
            next_d    = next_after_c;
            state_d   = SCHED_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = SCHED_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tm1638_bus_scheduler.sv
// Directed bench for tm1638_bus_scheduler: two requesters, watchdog at 8 (and 4 on a twin instance).
module tb_tm1638_bus_scheduler;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req, valid, last;
  logic [35:0] data;
  logic        full;

  logic [1:0]  grant, ready;
  logic [17:0] wdata;
  logic        write, tmo;
  logic [0:0]  src;

  logic [1:0]  grant4, ready4;
  logic [17:0] wdata4;
  logic        write4, tmo4;
  logic [0:0]  src4;

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0] exp_g [12] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10,
                             2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10};

  tm1638_bus_scheduler #(.NUM_REQ(2), .WORD_WIDTH(18), .TIMEOUT_CYCLES(8)) dut (
    .i_Clk(clk), .i_Rst(rst_n), .i_Req(req), .i_Valid(valid), .i_Last(last),
    .i_Data(data), .o_Grant(grant), .o_Ready(ready), .i_SPI_FIFO_Full(full),
    .o_Data(wdata), .o_Write(write), .o_Active_Src(src), .o_Timeout(tmo)
  );

  tm1638_bus_scheduler #(.NUM_REQ(2), .WORD_WIDTH(18), .TIMEOUT_CYCLES(4)) dut4 (
    .i_Clk(clk), .i_Rst(rst_n), .i_Req(req), .i_Valid(valid), .i_Last(last),
    .i_Data(data), .o_Grant(grant4), .o_Ready(ready4), .i_SPI_FIFO_Full(full),
    .o_Data(wdata4), .o_Write(write4), .o_Active_Src(src4), .o_Timeout(tmo4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0; req = '0; valid = '0; last = '0; data = '0; full = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++; if (grant !== 2'b00) begin n_errors++; $display("FAIL reset_grant: got %b want 00", grant); end
    n_checks++; if (src !== 1'b0) begin n_errors++; $display("FAIL reset_src: got %b want 0", src); end
    n_checks++; if (tmo !== 1'b0) begin n_errors++; $display("FAIL reset_timeout: got %b want 0", tmo); end
    n_checks++; if (ready !== 2'b00) begin n_errors++; $display("FAIL reset_ready: got %b want 00", ready); end
    n_checks++; if (write !== 1'b0 || wdata !== 18'h0) begin n_errors++; $display("FAIL reset_write: got %b/%h want 0/0", write, wdata); end
  endtask

  task automatic test_single();
    logic [17:0] words [3] = '{18'h00040, 18'h000C0, 18'h20001};
    do_reset();
    @(negedge clk); req = 2'b01; #1;
    n_checks++; if (grant !== 2'b00) begin n_errors++; $display("FAIL single_idle_grant: got %b want 00", grant); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); valid = 2'b01; data[17:0] = words[i]; last = (i == 2) ? 2'b01 : 2'b00;
      data[35:18] = 18'h3FFFF; #1;
      n_checks++; if (grant !== 2'b01 || ready !== 2'b01) begin n_errors++; $display("FAIL single_grant%0d: got %b/%b want 01/01", i, grant, ready); end
      n_checks++; if (write !== 1'b1 || wdata !== words[i]) begin n_errors++; $display("FAIL single_word%0d: got %b/%h want 1/%h", i, write, wdata, words[i]); end
    end
    @(negedge clk); req = 2'b00; valid = 2'b00; last = 2'b00; #1;
    n_checks++; if (grant !== 2'b00 || write !== 1'b0) begin n_errors++; $display("FAIL single_release: got %b/%b want 00/0", grant, write); end
  endtask

  task automatic test_back_to_back();
    int c0 = 0;
    int c1 = 0;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      req = 2'b11; valid = 2'b11;
      data[17:0]  = {2'b01, 16'(c0)};
      data[35:18] = {2'b10, 16'(c1)};
      last = {c1[0], c0[0]};
      #1;
      n_checks++; if (grant !== exp_g[c]) begin n_errors++; $display("FAIL b2b_grant c%0d: got %b want %b", c, grant, exp_g[c]); end
      n_checks++; if (write !== (exp_g[c] != 2'b00)) begin n_errors++; $display("FAIL b2b_write c%0d: got %b want %b", c, write, exp_g[c] != 2'b00); end
      if (exp_g[c] == 2'b01) begin
        n_checks++; if (wdata !== data[17:0]) begin n_errors++; $display("FAIL b2b_data c%0d: got %h want %h", c, wdata, data[17:0]); end
        c0++;
      end else if (exp_g[c] == 2'b10) begin
        n_checks++; if (wdata !== data[35:18]) begin n_errors++; $display("FAIL b2b_data c%0d: got %h want %h", c, wdata, data[35:18]); end
        c1++;
      end
    end
  endtask

  task automatic test_fifo_full();
    do_reset();
    @(negedge clk); req = 2'b01;
    @(negedge clk); valid = 2'b01; data[17:0] = 18'h00111; #1;
    n_checks++; if (write !== 1'b1 || wdata !== 18'h00111) begin n_errors++; $display("FAIL full_first: got %b/%h want 1/00111", write, wdata); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); full = 1'b1; data[17:0] = 18'h00222; #1;
      n_checks++; if (write !== 1'b0 || ready !== 2'b00) begin n_errors++; $display("FAIL full_hold%0d: got %b/%b want 0/00", i, write, ready); end
      n_checks++; if (write4 !== 1'b0 || ready4 !== 2'b00 || tmo4 !== 1'b0) begin n_errors++; $display("FAIL full_hold_t4_%0d: got %b/%b/%b want 0/00/0", i, write4, ready4, tmo4); end
    end
    @(negedge clk); full = 1'b0; #1;
    n_checks++; if (write4 !== 1'b1 || wdata4 !== 18'h00222 || tmo4 !== 1'b0) begin n_errors++; $display("FAIL full_resume: got %b/%h/%b want 1/00222/0", write4, wdata4, tmo4); end
    n_checks++; if (grant4 !== 2'b01) begin n_errors++; $display("FAIL full_grant_kept: got %b want 01", grant4); end
    @(negedge clk); data[17:0] = 18'h00333; last = 2'b01; #1;
    n_checks++; if (write4 !== 1'b1 || wdata4 !== 18'h00333) begin n_errors++; $display("FAIL full_last: got %b/%h want 1/00333", write4, wdata4); end
    @(negedge clk); req = 2'b00; valid = 2'b00; last = 2'b00; #1;
    n_checks++; if (grant4 !== 2'b00 || tmo4 !== 1'b0) begin n_errors++; $display("FAIL full_done: got %b/%b want 00/0", grant4, tmo4); end
  endtask

  task automatic test_timeout();
    do_reset();
    @(negedge clk); req = 2'b11; valid = 2'b00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      n_checks++; if (grant !== 2'b01 || tmo !== 1'b0) begin n_errors++; $display("FAIL tmo_stall%0d: got %b/%b want 01/0", i, grant, tmo); end
    end
    @(negedge clk); #1;
    n_checks++; if (tmo !== 1'b1 || grant !== 2'b00) begin n_errors++; $display("FAIL tmo_pulse: got %b/%b want 1/00", tmo, grant); end
    @(negedge clk); #1;
    n_checks++; if (tmo !== 1'b0 || grant !== 2'b10 || src !== 1'b1) begin n_errors++; $display("FAIL tmo_handover: got %b/%b/%b want 0/10/1", tmo, grant, src); end
  endtask

  task automatic test_reset_midburst();
    do_reset();
    @(negedge clk); req = 2'b01;
    @(negedge clk); valid = 2'b01; last = 2'b01; data[17:0] = 18'h00005;
    @(negedge clk); req = 2'b10; valid = 2'b00; last = 2'b00; #1;
    n_checks++; if (grant !== 2'b00) begin n_errors++; $display("FAIL rst_gap: got %b want 00", grant); end
    @(negedge clk); valid = 2'b10; data[35:18] = 18'h00006; #1;
    n_checks++; if (grant !== 2'b10 || write !== 1'b1 || wdata !== 18'h00006) begin n_errors++; $display("FAIL rst_pre: got %b/%b/%h want 10/1/00006", grant, write, wdata); end
    #3 rst_n = 1'b0;
    #1;
    n_checks++; if (grant !== 2'b00 || ready !== 2'b00) begin n_errors++; $display("FAIL rst_async_grant: got %b/%b want 00/00", grant, ready); end
    n_checks++; if (write !== 1'b0 || wdata !== 18'h0 || src !== 1'b0) begin n_errors++; $display("FAIL rst_async_write: got %b/%h/%b want 0/0/0", write, wdata, src); end
    @(negedge clk); rst_n = 1'b1; req = 2'b11; valid = 2'b00; #1;
    n_checks++; if (grant !== 2'b00) begin n_errors++; $display("FAIL rst_release: got %b want 00", grant); end
    @(negedge clk); #1;
    n_checks++; if (grant !== 2'b01 || src !== 1'b0) begin n_errors++; $display("FAIL rst_first_grant: got %b/%b want 01/0", grant, src); end
  endtask

  task automatic test_req_drop();
    logic [17:0] words [3] = '{18'h0A001, 18'h0A002, 18'h2A003};
    do_reset();
    @(negedge clk); req = 2'b01;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); valid = 2'b01; data[17:0] = words[i]; last = (i == 2) ? 2'b01 : 2'b00;
      if (i > 0) req = 2'b00;
      #1;
      n_checks++; if (grant !== 2'b01 || write !== 1'b1 || wdata !== words[i]) begin n_errors++; $display("FAIL drop_word%0d: got %b/%b/%h want 01/1/%h", i, grant, write, wdata, words[i]); end
    end
    @(negedge clk); valid = 2'b00; last = 2'b00; #1;
    n_checks++; if (grant !== 2'b00) begin n_errors++; $display("FAIL drop_release: got %b want 00", grant); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_timeout();
    test_reset_midburst();
    test_req_drop();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tm1638_bus_scheduler.md
# tm1638_bus_scheduler

Shares the single write port of `spi_fifo` between several TM1638 command producers, such as the display `tm1638_driver` and a key-scan command issuer. Each producer delivers an atomic transaction: a burst of 18-bit command words ending with a last-word marker. The scheduler grants the port round-robin at transaction boundaries and forwards words with zero latency under FIFO backpressure. A watchdog reclaims the port from a granted requester that stalls.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters, 2..8.
- `WORD_WIDTH`, 18: command word width; matches the `spi_fifo` data input.
- `TIMEOUT_CYCLES`, 1024: stall cycles tolerated inside a granted burst; must be ≥ 2.

Ports:
- `i_Clk` in 1: clock; all state updates on its rising edge.
- `i_Rst` in 1: reset, asynchronous and active-low.
- `i_Req` in `NUM_REQ`: requester k has a transaction pending.
- `i_Valid` in `NUM_REQ`: requester k presents a word.
- `i_Last` in `NUM_REQ`: requester k's presented word ends its transaction.
- `i_Data` in `NUM_REQ`×`WORD_WIDTH`: packed words; requester k occupies `[k*WORD_WIDTH +: WORD_WIDTH]`.
- `o_Grant` out `NUM_REQ`: registered, one-hot or zero.
- `o_Ready` out `NUM_REQ`: combinational; the word of requester k is accepted this cycle.
- `i_SPI_FIFO_Full` in 1: full flag from `spi_fifo`.
- `o_Data` out `WORD_WIDTH`: combinational, to `spi_fifo` `i_Data`.
- `o_Write` out 1: combinational, to `spi_fifo` `i_Data_Valid`.
- `o_Active_Src` out `$clog2(NUM_REQ)`: registered index of the granted requester.
- `o_Timeout` out 1: registered, one-cycle pulse.

## Operation
- State `SCHED_IDLE`:
  - `o_Grant`=0 and `o_Ready`=0.
  - If `i_Req`≠0, pick the first set bit scanning upward (with wrap) from pointer `r_Next`.
  - Load `o_Grant`, `o_Active_Src` and `r_Grant_Idx`, clear the stall counter, and go to `SCHED_BURST`.
- State `SCHED_BURST`, with g = granted index:
  - `o_Ready[g]` = ~`i_SPI_FIFO_Full`; all other `o_Ready` bits are 0.
  - Transfer condition: `i_Valid[g]` & `o_Ready[g]`.
  - On a transfer, `o_Write`=1 and `o_Data`=word g. Otherwise `o_Write`=0 and `o_Data`=0.
  - A transfer with `i_Last[g]`=1: clear grant, set `r_Next`=(g+1) mod `NUM_REQ`, go to `SCHED_IDLE`.
- Non-granted requesters' valid, last and data are ignored entirely.
- `i_Req[g]` deasserting mid-burst is ignored; the grant holds until a last word or a timeout.
- Watchdog:
  - The stall counter increments on each `SCHED_BURST` cycle with no transfer and FIFO not full.
  - It holds while the FIFO is full, since backpressure is not a stall.
  - It clears on every transfer.
  - When it reaches `TIMEOUT_CYCLES`-1 on a stall cycle, pulse `o_Timeout`, drop the grant, advance `r_Next` past g, and go to `SCHED_IDLE`.
  - The truncated transaction is not repaired; recovery is the requester's duty.
- Simultaneous last-word transfer and timeout threshold cannot occur, because a transfer clears the counter. The last-word transfer wins.
- Counter width is `$clog2(TIMEOUT_CYCLES)`; it never wraps.
- Reset (asynchronous, active-low) applies the following immediately, including mid-burst:
  - state=`SCHED_IDLE`, `r_Next`=0, counter=0.
  - `o_Grant`=0, `o_Active_Src`=0, `o_Timeout`=0; `o_Ready`, `o_Write` and `o_Data` go to 0.
  - `spi_fifo` shares the reset, so no partial transaction survives.

## Timing
- Request sampled at edge t → `o_Grant` high after edge t; first write possible in the cycle after edge t.
- Throughput: one word per cycle while the FIFO is not full.
- Forwarding is zero-latency (combinational). No write is ever issued while `i_SPI_FIFO_Full`=1.
- Last word transferred in cycle c → grant low after edge c. The next grant comes one edge later, leaving exactly one dead cycle between transactions.
- `o_Timeout` is high for the single cycle following the threshold edge, coincident with `o_Grant`=0.

## Structure
- Package `tm1638_sched_types` holds:
  - `sched_state_t` enum: `SCHED_IDLE`, `SCHED_BURST`.
  - `WORD_WIDTH` default constant.
- Sub-module `rr_pick`: combinational round-robin picker. Inputs are request vector and pointer; outputs are one-hot grant, index and any-request flag. It is parameterised by `NUM_REQ`.
- Top contains the FSM, stall counter and output muxing.

## Test plan
- Single requester 0, 3 words 0x00040, 0x000C0, 0x20001 (last) → `o_Write` for 3 consecutive cycles with those exact values; grant low after the last word; one idle cycle.
- Both requesters continuously requesting, 2-word transactions → grant order 0,1,0,1; each burst is uninterrupted; never both grants high.
- FIFO full asserted for 5 cycles mid-burst → `o_Write`=0 and `o_Ready`=0 for those 5 cycles; no timeout with `TIMEOUT_CYCLES`=4; burst completes afterwards.
- Granted requester drops `i_Valid` with `TIMEOUT_CYCLES`=8 → after 8 stall cycles, `o_Timeout` pulses once; grant passes to requester 1 on the next edge.
- Reset asserted mid-burst (asynchronously, between edges) → `o_Grant`, `o_Ready` and `o_Write` go low immediately. After release, the first grant goes to the lowest requesting index.
- `i_Req[g]` deasserted mid-burst while words continue → all words forwarded; grant held until the last word.
